// File: rtl/param_seq_detector.sv
// Mealy serial pattern detector: NUM_PAT programmable SEQ_LEN-bit patterns, framed or sliding.
// Optional saturating match counter enabled by defining PARAM_SEQ_DETECTOR_MATCH_CNT_EN.
module param_seq_detector #(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned NUM_PAT = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       in_valid,
  input  logic                       clr,
  input  logic                       mode,
  input  logic [NUM_PAT*SEQ_LEN-1:0] pat_flat,
  input  logic [NUM_PAT-1:0]         pat_en,
  output logic                       dec,
  output logic [2:0]                 match_id,
  output logic [CNT_W-1:0]           match_cnt
);

  localparam int unsigned HIST_W = SEQ_LEN - 1;
  localparam int unsigned IDX_W  = $clog2(SEQ_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SEQ_LEN - 1);

  logic [HIST_W-1:0]  hist;
  logic [IDX_W-1:0]   fill;
  logic [IDX_W-1:0]   fidx;
  logic [SEQ_LEN-1:0] cand;
  logic [NUM_PAT-1:0] hit;
  logic               armed;
  logic               accept;
  logic [2:0]         low_id;

  assign accept = in_valid && !rst && !clr;
  assign cand   = {hist, in};

  // Per-slot compare against the live pattern table
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_PAT); i++) begin
      hit[i] = pat_en[i] && (cand == pat_flat[i*SEQ_LEN +: SEQ_LEN]);
    end
  end

  // Lowest-index hit wins
  always_comb begin
    low_id = 3'd0;
    for (int i = int'(NUM_PAT) - 1; i >= 0; i--) begin
      if (hit[i]) low_id = 3'(i);
    end
  end

  // Framed mode fires only at frame end; sliding mode once the history is primed
  assign armed    = mode ? (fill == LAST) : (fidx == LAST);
  assign dec      = accept && armed && (|hit);
  assign match_id = dec ? low_id : 3'd0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
      fidx <= '0;
    end else if (in_valid) begin
      hist <= HIST_W'(cand);
      fill <= (fill == LAST) ? LAST : fill + IDX_W'(1);
      fidx <= (fidx == LAST) ? '0 : fidx + IDX_W'(1);
    end
  end

`ifdef PARAM_SEQ_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Saturating match counter; survives clr
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (dec && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule
